// File: rtl/io_ctrl.sv
// io_ctrl: CPU-facing user I/O block. A debounced confirm button captures the
// switch value into du during an input instruction. Output instructions queue
// dm values for the 7-segment display.
// Ports: clk/rst_n (async active-low); inop/outop instruction strobes; bt raw
//   button; in switches; dm value to display; du captured input; disp/disp_valid
//   display value and "something shown" flag; await combinational CPU stall.
// Latency: du loads on the press edge and disp follows the FIFO head. In the
//   register build, disp updates the cycle after outop.
// Backpressure: await holds the CPU while an input is pending. It also holds
//   the CPU while outop hits a FIFO that cannot take an entry this cycle.
// Config: define IO_CTRL_OUTFIFO_EN for the FIFO with a hold timer. Without it,
//   the build uses a single output register.
module io_ctrl #(
  parameter int DATA_W      = 32,
  parameter int IN_W        = 14,
  parameter int DISP_W      = 14,
  parameter int DEB_CYCLES  = 50000,
  parameter int OUT_DEPTH   = 4,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inop,
  input  logic              outop,
  input  logic              bt,
  input  logic [IN_W-1:0]   in,
  input  logic [DATA_W-1:0] dm,
  output logic [DATA_W-1:0] du,
  output logic [DISP_W-1:0] disp,
  output logic              disp_valid,
  output logic              await
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_REL, S_WAIT_PRESS, S_DONE} state_t;

  logic          bt_s1, bt_s2;
  logic          deb_lvl;
  logic [DW-1:0] deb_cnt;
  logic          press;
  state_t        state, state_nxt;
  logic          du_load;
  logic          out_stall;

  // Button synchroniser and debouncer. The level flips on the DEB_CYCLES-th
  // consecutive sample that disagrees with it. A flip to 1 is the press event.
  // The press event is registered, so it is high for exactly the first cycle
  // that deb_lvl reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bt_s1   <= 1'b0;
      bt_s2   <= 1'b0;
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      bt_s1 <= bt;
      bt_s2 <= bt_s1;
      press <= 1'b0;
      if (bt_s2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_lvl <= bt_s2;
        deb_cnt <= '0;
        press   <= bt_s2;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Input FSM. Dropping inop abandons a pending capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    du_load   = 1'b0;
    case (state)
      S_IDLE:       if (inop) state_nxt = deb_lvl ? S_WAIT_REL : S_WAIT_PRESS;
      S_WAIT_REL:   if (!inop) state_nxt = S_IDLE;
                    else if (!deb_lvl) state_nxt = S_WAIT_PRESS;
      S_WAIT_PRESS: if (!inop) state_nxt = S_IDLE;
                    else if (press) begin
                      du_load   = 1'b1;
                      state_nxt = S_DONE;
                    end
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       du <= '0;
    else if (du_load) du <= DATA_W'(in);
  end

  assign await = (inop && (state != S_DONE)) || (outop && !inop && out_stall);

`ifdef IO_CTRL_OUTFIFO_EN
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [DISP_W-1:0] mem [OUT_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [HW-1:0]     hold_cnt;
  logic              full, pop, push;
  logic              unused_dm;

  assign unused_dm = ^dm;
  assign full      = (count == CW'(OUT_DEPTH));
  // The head leaves only after a full hold and only if a successor is waiting.
  // The last entry therefore stays on the display indefinitely.
  assign pop       = (count > CW'(1)) && (hold_cnt == HOLD_LAST);
  // A slot freed by a same-cycle pop is usable at once. The stall therefore
  // reflects "cannot accept now" rather than raw occupancy.
  assign out_stall = full && !pop;
  assign push      = outop && !inop && !out_stall;
  // Entries are zero after reset, so the empty FIFO displays 0.
  assign disp      = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_cnt   <= '0;
      disp_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dm[DISP_W-1:0];
        wr_ptr      <= wr_ptr + AW'(1);
        disp_valid  <= 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        hold_cnt <= '0;
      end else if ((count != '0) && (hold_cnt != HOLD_LAST)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
`else
  logic [DISP_W-1:0] out_reg;
  logic              unused_cfg;

  assign unused_cfg = (^dm) ^ (OUT_DEPTH > 0) ^ (HOLD_CYCLES > 0);
  assign out_stall  = 1'b0;
  assign disp       = out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg    <= '0;
      disp_valid <= 1'b0;
    end else if (outop && !inop) begin
      out_reg    <= dm[DISP_W-1:0];
      disp_valid <= 1'b1;
    end
  end
`endif

endmodule
